// File: rtl/watch_set_if.sv
// Board-side bus of the watch set controller: raw keys, setting switches,
// and the count-enable / load-strobe outputs toward the time registers.
interface watch_set_if;
  logic       mode_btn;
  logic       set_btn;
  logic [5:0] val;
  logic       tick;
  logic       blink;
  logic [1:0] sel;
  logic       ld_hour;
  logic       ld_min;
  logic       ld_sec;
  logic [5:0] ld_val;
  logic       err;

  modport master (
    output mode_btn, set_btn, val,
    input  tick, blink, sel, ld_hour, ld_min, ld_sec, ld_val, err
  );

  modport slave (
    input  mode_btn, set_btn, val,
    output tick, blink, sel, ld_hour, ld_min, ld_sec, ld_val, err
  );
endinterface

// File: rtl/watch_set_ctrl.sv
// Watch time-setting sequencer: key debounce, RUN/SET_* walk, range-checked
// load strobes, 1 Hz tick, half-second blink and inactivity timeout.
//
//   state    | meaning
//   ---------+---------------------------------------------
//   RUN      | time counts; tick enabled, set key ignored
//   SET_HOUR | set key loads hour field (0..23)
//   SET_MIN  | set key loads minute field (0..59)
//   SET_SEC  | set key loads second field (0..59)
module watch_set_ctrl #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int DEBOUNCE  = 500_000,
  parameter int TIMEOUT_S = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  watch_set_if.slave bus
);

  localparam int PS_W = $clog2(CLK_HZ);
  localparam int DB_W = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;
  localparam int TO_W = $clog2(TIMEOUT_S + 1);

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_HZ - 1);
  localparam logic [PS_W-1:0] PS_HALF = PS_W'(CLK_HZ / 2 - 1);
  localparam logic [DB_W-1:0] DB_DONE = DB_W'(DEBOUNCE);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_S - 1);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10,
    SET_SEC  = 2'b11
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      key_raw;
  logic [1:0]      sync1, sync2;
  logic [1:0]      deb, deb_q;
  logic [DB_W-1:0] db_cnt [2];
  logic            mode_press, set_press, press_any;
  logic [PS_W-1:0] pre_q;
  logic            sec_evt;
  logic            blink_q, tick_q;
  logic [TO_W-1:0] to_q, to_d;
  logic [2:0]      ld_q, ld_d;
  logic [5:0]      ld_val_q, ld_val_d;
  logic            err_q, err_d;
  logic [5:0]      limit;
  logic            run_entry;

  assign key_raw    = {bus.set_btn, bus.mode_btn};
  assign mode_press = deb[0] & ~deb_q[0];
  assign set_press  = deb[1] & ~deb_q[1];
  assign press_any  = mode_press | set_press;
  assign sec_evt    = (pre_q == PS_LAST);
  assign limit      = (state_q == SET_HOUR) ? 6'd23 : 6'd59;

  // Key path: 2-flop sync, then accept a new level only after it has held
  // for DEBOUNCE cycles; any bounce back to the old level restarts the count.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int k = 0; k < 2; k++) db_cnt[k] <= '0;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
      deb_q <= deb;
      for (int k = 0; k < 2; k++) begin
        if (sync2[k] == deb[k]) begin
          db_cnt[k] <= '0;
        end else if (db_cnt[k] == DB_DONE) begin
          deb[k]    <= sync2[k];
          db_cnt[k] <= '0;
        end else begin
          db_cnt[k] <= db_cnt[k] + DB_W'(1);
        end
      end
    end
  end

  // Prescaler restarts on entry to RUN so the first tick is a full second away.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pre_q   <= '0;
      blink_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      if (run_entry || sec_evt) pre_q <= '0;
      else                      pre_q <= pre_q + PS_W'(1);
      if (pre_q == PS_HALF || sec_evt) blink_q <= ~blink_q;
      tick_q <= (state_q == RUN) && sec_evt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= RUN;
      to_q     <= '0;
      ld_q     <= '0;
      ld_val_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      to_q     <= to_d;
      ld_q     <= ld_d;
      ld_val_q <= ld_val_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    to_d      = to_q;
    ld_d      = 3'b000;
    ld_val_d  = ld_val_q;
    err_d     = err_q;
    run_entry = 1'b0;

    // Set action uses the field of the current state even if mode advances now.
    if (set_press && state_q != RUN) begin
      if (bus.val <= limit) begin
        ld_val_d = bus.val;
        err_d    = 1'b0;
        case (state_q)
          SET_HOUR: ld_d = 3'b001;
          SET_MIN:  ld_d = 3'b010;
          SET_SEC:  ld_d = 3'b100;
          default:  ld_d = 3'b000;
        endcase
      end else begin
        err_d = 1'b1;
      end
    end

    if (mode_press) begin
      case (state_q)
        RUN:      state_d = SET_HOUR;
        SET_HOUR: state_d = SET_MIN;
        SET_MIN:  state_d = SET_SEC;
        default:  state_d = RUN;
      endcase
    end

    if (state_q == RUN) begin
      to_d = '0;
    end else if (press_any) begin
      to_d = '0;
    end else if (sec_evt) begin
      if (to_q == TO_LAST) begin
        to_d    = '0;
        state_d = RUN;
      end else begin
        to_d = to_q + TO_W'(1);
      end
    end

    run_entry = (state_q != RUN) && (state_d == RUN);
  end

  assign bus.sel     = state_q;
  assign bus.tick    = tick_q;
  assign bus.blink   = blink_q;
  assign bus.ld_hour = ld_q[0];
  assign bus.ld_min  = ld_q[1];
  assign bus.ld_sec  = ld_q[2];
  assign bus.ld_val  = ld_val_q;
  assign bus.err     = err_q;

endmodule

// File: doc/watch_set_ctrl.md
# watch_set_ctrl

Control FSM that sequences the time-setting datapath of the lab watch. It debounces the mode and set push-buttons and walks through RUN, SET_HOUR, SET_MIN and SET_SEC. It issues range-checked single-cycle load strobes for the selected field. It also generates the 1 Hz count enable and the half-second blink, and returns to RUN after an inactivity timeout. It sits between the board keys/switches and the hour/minute/second counter registers, which count on `tick` and load `ld_val` on the strobes.

## Interface
- `CLK_HZ`, default 50_000_000: clock cycles per second; must be even and ≥ 4.
- `DEBOUNCE`, default 500_000: consecutive stable cycles required before a key level is accepted.
- `TIMEOUT_S`, default 10: seconds without a press in a SET state before forced return to RUN.

- `clk`  in  1: system clock. Every flop is clocked on the rising edge.
- `reset_n`  in  1: synchronous, active-low reset.
- `mode_btn`  in  1: raw mode key, 1 = pressed, asynchronous.
- `set_btn`  in  1: raw set key, 1 = pressed, asynchronous.
- `val`  in  6: setting value (SW[5:0]).
- `tick`  out  1: 1-cycle count enable, once per second, in RUN only.
- `blink`  out  1: toggles every CLK_HZ/2 cycles.
- `sel`  out  2: current state, 00 RUN, 01 SET_HOUR, 10 SET_MIN, 11 SET_SEC.
- `ld_hour`, `ld_min`, `ld_sec`  out  1 each: 1-cycle load strobes; at most one high per cycle.
- `ld_val`  out  6: value to load; valid while any strobe is high, holds last value otherwise.
- `err`  out  1: last set press was out of range; sticky until the next accepted press.

## Operation
- Reset (reset_n=0 at a clock edge) clears everything to 0: `sel`=00 (RUN), all strobes, `ld_val`, `err`, `blink`, `tick`, prescaler, timeout counter, and synchronizer/debounce state. Reset mid-setting abandons the setting with no strobe.
- **Key path** (per key):
  - 2-flop synchronizer.
  - The debounced level copies the synced level once the two have differed for DEBOUNCE consecutive cycles. Any bounce back restarts the count.
  - A press is the 0→1 transition of the debounced level, lasting 1 cycle. Releases produce no event.
  - Holding a key produces exactly one press.
- **Prescaler**:
  - Runs 0..CLK_HZ-1 and wraps.
  - `blink` toggles when the count is CLK_HZ/2-1 and when it is CLK_HZ-1.
  - A wrap is a "second" event.
- **RUN**:
  - `tick` pulses on each second event.
  - Set presses are ignored, with no strobe and `err` unchanged.
  - A mode press moves to SET_HOUR.
- **SET states**:
  - `tick` is held 0.
  - A mode press advances SET_HOUR→SET_MIN→SET_SEC→RUN.
  - A set press checks `val` against the limit for the current field: 23 for hour, 59 for min/sec.
    - In range: one strobe for the current field, `ld_val`=`val`, `err`=0.
    - Out of range: no strobe, `err`=1.
- **Simultaneous mode and set press in the same cycle**: the set action applies to the field of the pre-transition state, and the state advances in the same edge.
- **Timeout**:
  - The timeout counter counts second events while in a SET state and clears on any press.
  - When it reaches TIMEOUT_S it forces RUN and clears itself. No strobe is issued.
- **Entry to RUN** (by mode press or timeout):
  - The prescaler is cleared, so the first `tick` comes exactly CLK_HZ cycles after `sel` shows 00.
  - `blink` is unaffected.

## Timing
- All outputs are registered. No combinational input→output paths.
- Press latency: from the first edge sampling a raw key high (stable, no bounce) to `sel` or strobe change is 2 + DEBOUNCE + 1 cycles.
- Strobes are exactly 1 cycle wide. `err` changes in the same cycle a strobe would.
- `tick` period is CLK_HZ cycles. `blink` period is CLK_HZ cycles at 50% duty.
- Timeout fires on the TIMEOUT_S-th second event after the last press; `sel`=00 the following cycle.

## Test plan
All scenarios use CLK_HZ=10, DEBOUNCE=3, TIMEOUT_S=2.
- **Reset and free-run**: reset for 2 cycles, then run 40 cycles → all outputs 0 after reset; `tick` pulses every 10 cycles; `blink` toggles every 5; `sel`=00.
- **Mode cycling**: 4 clean mode presses → `sel` goes 01, 10, 11, 00, each change 6 cycles after the raw rise; no strobes; `tick` resumes exactly 10 cycles after return to RUN.
- **Loads**:
  - In SET_HOUR, `val`=23 and set press → `ld_hour` 1 cycle, `ld_val`=23, `err`=0.
  - `val`=24 and set press → no strobe, `err`=1.
  - In SET_MIN, `val`=59 and set press → `ld_min`, `err`=0.
- **Debounce**: mode key bounces 1-0-1-0 at 1-cycle spacing, then holds high for 20 cycles → exactly one press; `sel` changes once; the hold yields no repeats.
- **Simultaneous press**: in SET_SEC, `val`=30, mode and set rise on the same cycle → `ld_sec` with `ld_val`=30, and `sel`=00 on the same edge.
- **Timeout and reset mid-op**:
  - Enter SET_MIN and stay idle → `sel`=00 after the 2nd second event; no strobe.
  - Re-enter SET_HOUR, assert reset_n=0 during a set press's debounce → `sel`=00; no strobe ever issued.
